// File: rtl/arbitro_ula_4.sv
// arbitro_ula_4: round-robin arbiter and sequencer that shares one ULA between
// four requesters. It picks a winner, forwards its opcode, pulses ula_start,
// waits for ula_done and acknowledges the winner. All outputs are registered.
// Optional WAIT-state timeout: define ARBITRO_TIMEOUT_EN to enable it.
`timescale 1ns/1ps
module arbitro_ula_4 #(
    parameter int OP_W           = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        req,
    input  logic [4*OP_W-1:0] op_in,
    input  logic              ula_done,
    output logic [3:0]        grant,
    output logic              ula_start,
    output logic [OP_W-1:0]   ula_op,
    output logic [3:0]        ack,
    output logic              busy,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [1:0]      r_idx;
    logic [1:0]      w_idx_next;
    logic [1:0]      r_ptr;
    logic [1:0]      w_ptr_next;
    logic [OP_W-1:0] r_op;
    logic [OP_W-1:0] w_op_next;

    logic [3:0]      r_grant;
    logic [3:0]      w_grant_next;
    logic [3:0]      r_ack;
    logic [3:0]      w_ack_next;
    logic            r_start;
    logic            w_start_next;
    logic            r_busy;
    logic            w_busy_next;

    // Rotated search: slot k holds requester (ptr + k) mod 4
    logic [1:0]      w_slot [4];
    logic [3:0]      w_cand;
    logic [3:0]      w_idx_onehot;
    logic [OP_W-1:0] w_op_arr [4];
    logic [1:0]      w_winner;

`ifdef ARBITRO_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_to_flag;
    logic             w_to_flag_next;
    logic             r_terr;
    logic             w_terr_next;
`endif

    generate
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
            $error("arbitro_ula_4: TIMEOUT_CYCLES must be >= 1");
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_port
            assign w_op_arr[gi]     = op_in[gi*OP_W +: OP_W];
            assign w_slot[gi]       = r_ptr + 2'(gi);
            assign w_cand[gi]       = req[w_slot[gi]];
            assign w_idx_onehot[gi] = (r_idx == 2'(gi));
        end
    endgenerate

    // First asserted request at or after the priority pointer
    always_comb begin
        w_winner = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            if (w_cand[k]) begin
                w_winner = w_slot[k];
            end
        end
    end

    // Next-state logic and next values of the registered outputs
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_ptr_next   = r_ptr;
        w_op_next    = r_op;
        w_grant_next = 4'b0000;
        w_ack_next   = 4'b0000;
        w_start_next = 1'b0;
        w_busy_next  = 1'b0;
`ifdef ARBITRO_TIMEOUT_EN
        w_cnt_next     = r_cnt;
        w_to_flag_next = r_to_flag;
        w_terr_next    = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_idx_next   = w_winner;
                    w_op_next    = w_op_arr[w_winner];
                    w_state_next = S_START;
                end
            end
            S_START: begin
                // ula_done is deliberately not looked at here
                w_grant_next = w_idx_onehot;
                w_start_next = 1'b1;
                w_busy_next  = 1'b1;
                w_state_next = S_WAIT;
`ifdef ARBITRO_TIMEOUT_EN
                w_cnt_next     = '0;
                w_to_flag_next = 1'b0;
`endif
            end
            S_WAIT: begin
                w_grant_next = w_idx_onehot;
                w_busy_next  = 1'b1;
                if (ula_done) begin
                    // Completion wins over a simultaneous expiry
                    w_state_next = S_DONE;
                end
`ifdef ARBITRO_TIMEOUT_EN
                else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    w_state_next   = S_DONE;
                    w_to_flag_next = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
`endif
            end
            S_DONE: begin
                w_grant_next = w_idx_onehot;
                w_busy_next  = 1'b1;
                w_ptr_next   = r_idx + 2'd1;
                w_state_next = S_IDLE;
`ifdef ARBITRO_TIMEOUT_EN
                if (r_to_flag) begin
                    w_terr_next = 1'b1;
                end else begin
                    w_ack_next = w_idx_onehot;
                end
`else
                w_ack_next = w_idx_onehot;
`endif
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State, winner index, priority pointer and captured opcode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= 2'd0;
            r_ptr   <= 2'd0;
            r_op    <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_ptr   <= w_ptr_next;
            r_op    <= w_op_next;
        end
    end

    // Registered outputs, one cycle behind the state that produces them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant <= 4'b0000;
            r_ack   <= 4'b0000;
            r_start <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_grant <= w_grant_next;
            r_ack   <= w_ack_next;
            r_start <= w_start_next;
            r_busy  <= w_busy_next;
        end
    end

`ifdef ARBITRO_TIMEOUT_EN
    // WAIT-cycle counter, expiry flag and the timeout pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_to_flag <= 1'b0;
            r_terr    <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_next;
            r_to_flag <= w_to_flag_next;
            r_terr    <= w_terr_next;
        end
    end
    assign timeout_err = r_terr;
`else
    assign timeout_err = 1'b0;
`endif

    assign grant     = r_grant;
    assign ack       = r_ack;
    assign ula_start = r_start;
    assign busy      = r_busy;
    assign ula_op    = r_op;

endmodule
